// File: rtl/seg7_scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux_pkg
//   Shared segment definitions for the 7-segment display blocks. It holds the
//   bit positions on the 8-bit segment bus, the hex glyph patterns and the
//   blank pattern.
//   Segment bus layout, active-high: bit0=a ... bit6=g, bit7=decimal point.
// -----------------------------------------------------------------------------
package seg7_scan_mux_pkg;

  // Bit positions on the segment bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs, bits g..a
  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  // Whole bus off: no segments and no decimal point
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_scan_mux_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
//   Combinational decoder from a hex nibble to a 7-segment glyph. Other
//   display blocks reuse it.
//   Ports:
//     i_hex  [3:0]  nibble to display
//     o_seg  [6:0]  segment pattern, active-high, bit0=a ... bit6=g
// -----------------------------------------------------------------------------
module hex_to_7seg
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = HEX_0;
    unique case (i_hex)
      4'h0: o_seg = HEX_0;
      4'h1: o_seg = HEX_1;
      4'h2: o_seg = HEX_2;
      4'h3: o_seg = HEX_3;
      4'h4: o_seg = HEX_4;
      4'h5: o_seg = HEX_5;
      4'h6: o_seg = HEX_6;
      4'h7: o_seg = HEX_7;
      4'h8: o_seg = HEX_8;
      4'h9: o_seg = HEX_9;
      4'hA: o_seg = HEX_A;
      4'hB: o_seg = HEX_B;
      4'hC: o_seg = HEX_C;
      4'hD: o_seg = HEX_D;
      4'hE: o_seg = HEX_E;
      4'hF: o_seg = HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexed scanner for an N-digit common-cathode 7-segment display.
//   The block holds a hex word and shows one digit per scan slot. Each slot
//   opens with a fully blanked guard interval to stop ghosting. A new word is
//   loaded tear-free: it only reaches the display at a frame boundary.
//   Ports:
//     clk          system clock
//     rst          synchronous reset, active-high
//     load         capture data/dp this cycle
//     data         hex nibbles, nibble i = digit i, digit 0 least significant
//     dp           decimal point per digit, captured with data
//     lzb          leading-zero blanking enable (live)
//     outbus[7:0]  segment pattern, active-high, bit7 = dp
//     digit_n      cathode selects, active-low, at most one low
//     pending      a loaded word is waiting for the next frame boundary
//     frame_start  one-cycle pulse in the first cycle of digit 0's slot
// -----------------------------------------------------------------------------
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lzb,
  output logic [7:0]              outbus,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  // Scan position
  logic [PW-1:0] r_prescaler;
  logic [IW-1:0] r_index;

  // Display word and the word waiting for the next frame boundary
  logic [4*NUM_DIGITS-1:0] r_disp_data;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pending;

  // Registered outputs
  logic [7:0]            r_outbus;
  logic [NUM_DIGITS-1:0] r_digit_n;
  logic                  r_frame_start;

  logic                    w_tick;
  logic                    w_last;
  logic                    w_boundary;
  logic                    w_guard;
  logic [4*NUM_DIGITS-1:0] w_upper;
  logic                    w_lz_blank;
  logic [6:0]              w_seg;
  logic [7:0]              w_pattern;

  assign w_tick     = (r_prescaler == PW'(CLK_DIV - 1));
  assign w_last     = (r_index == IW'(NUM_DIGITS - 1));
  assign w_boundary = w_tick & w_last;
  assign w_guard    = (r_prescaler < PW'(GUARD));

  // Shifting the word down to the current digit leaves only that nibble
  // and the more significant ones. If all of them are zero, the digit is a
  // leading zero. Digit 0 always shows, so a value of zero still reads "0".
  assign w_upper    = r_disp_data >> {r_index, 2'b00};
  assign w_lz_blank = lzb && (r_index != '0) && (w_upper == '0);

  hex_to_7seg u_dec (
    .i_hex (w_upper[3:0]),
    .o_seg (w_seg)
  );

  // A blanked digit keeps its decimal point
  always_comb begin
    w_pattern         = SEG_BLANK;
    w_pattern[6:0]    = w_lz_blank ? 7'h00 : w_seg;
    w_pattern[SEG_DP] = r_disp_dp[r_index];
  end

  // Prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescaler <= '0;
      r_index     <= '0;
    end else if (w_tick) begin
      r_prescaler <= '0;
      r_index     <= w_last ? '0 : r_index + 1'b1;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

  // Tear-free load. The display word changes only on a frame boundary. A
  // load that coincides with the boundary goes straight to the display and
  // overrides any older pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_data <= '0;
      r_disp_dp   <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pending   <= 1'b0;
    end else if (w_boundary) begin
      if (load) begin
        r_disp_data <= data;
        r_disp_dp   <= dp;
      end else if (r_pending) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_pend_data <= data;
      r_pend_dp   <= dp;
      r_pending   <= 1'b1;
    end
  end

  // The outputs are registered from the current scan position, so they lag
  // the index/prescaler by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outbus      <= SEG_BLANK;
      r_digit_n     <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if (w_guard) begin
        r_outbus  <= SEG_BLANK;
        r_digit_n <= '1;
      end else begin
        r_outbus  <= w_pattern;
        r_digit_n <= ~(NUM_DIGITS'(1) << r_index);
      end
    end
  end

  assign outbus      = r_outbus;
  assign digit_n     = r_digit_n;
  assign pending     = r_pending;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_mux
//   Bench for seg7_scan_mux with 4 digits, 4 cycles per slot and a 1-cycle
//   guard. The reference model works out the scan position from the number
//   of cycles since reset and keeps the display/pending words as plain
//   values. Directed checks pin individual glyphs to hand-computed values.
// -----------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int GRD   = 1;
  localparam int FRAME = N * DIV;
  localparam int BUDGET = 4 * FRAME;

  // ---------------- clock / reset / DUT ----------------
  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic        lzb  = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp   = '0;
  logic [7:0]  outbus;
  logic [3:0]  digit_n;
  logic        pending;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS (N),
    .CLK_DIV    (DIV),
    .GUARD      (GRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data        (data),
    .dp          (dp),
    .lzb         (lzb),
    .outbus      (outbus),
    .digit_n     (digit_n),
    .pending     (pending),
    .frame_start (frame_start)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_disp  = '0;
  logic [3:0]  m_ddp   = '0;
  logic [15:0] m_pdata = '0;
  logic [3:0]  m_pdp   = '0;
  bit          m_pend  = 1'b0;
  logic [7:0]  e_outbus;
  logic [3:0]  e_digit_n;
  logic        e_fs;
  logic        e_pend;

  // Digit idx is a leading zero if it and every digit above it is 0
  function automatic bit leading_zero(input logic [15:0] v, input int idx);
    if (idx == 0) return 1'b0;
    for (int j = idx; j < N; j++)
      if (v[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int p;
    int idx;
    bit bnd;
    logic [3:0] nib;
    if (rst) begin
      m_valid   = 1'b1;
      m_cnt     = 0;
      m_disp    = '0;
      m_ddp     = '0;
      m_pend    = 1'b0;
      e_outbus  = 8'h00;
      e_digit_n = 4'hF;
      e_fs      = 1'b0;
      e_pend    = 1'b0;
    end else if (m_valid) begin
      p   = m_cnt % DIV;
      idx = (m_cnt / DIV) % N;
      if (p < GRD) begin
        e_outbus  = 8'h00;
        e_digit_n = 4'hF;
      end else begin
        nib            = m_disp[4*idx +: 4];
        e_outbus[6:0]  = (lzb && leading_zero(m_disp, idx)) ? 7'h00 : seg_lut[nib];
        e_outbus[7]    = m_ddp[idx];
        e_digit_n      = 4'hF;
        e_digit_n[idx] = 1'b0;
      end
      bnd  = (m_cnt % FRAME) == FRAME - 1;
      e_fs = bnd;
      if (bnd) begin
        if (load) begin
          m_disp = data;
          m_ddp  = dp;
        end else if (m_pend) begin
          m_disp = m_pdata;
          m_ddp  = m_pdp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pdata = data;
        m_pdp   = dp;
        m_pend  = 1'b1;
      end
      e_pend = m_pend;
      m_cnt++;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_outbus", outbus, e_outbus);
      check("model_digit_n", {4'h0, digit_n}, {4'h0, e_digit_n});
      check("model_frame_start", {7'h0, frame_start}, {7'h0, e_fs});
      check("model_pending", {7'h0, pending}, {7'h0, e_pend});
      n_cmp++;
      if ($countones(~digit_n) > 1) begin
        n_fail++;
        $display("FAIL onehot_digit_n @%0t: got %b, want at most one low", $time, digit_n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1;
    data = d;
    dp   = p;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no frame_start, want one within %0d cycles", nm, BUDGET);
    end
  endtask

  task automatic wait_digit(input int d, input string nm, output bit ok);
    logic [3:0] sel;
    sel = 4'hF;
    sel[d] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      if (digit_n === sel) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no active digit %0d, want it within %0d cycles", nm, d, BUDGET);
    end
  endtask

  task automatic expect_digit(input int d, input logic [7:0] pat, input string nm);
    bit ok;
    wait_digit(d, nm, ok);
    if (ok) check(nm, outbus, pat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    bit hit;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outbus", outbus, 8'h00);
    check("rst_digit_n", {4'h0, digit_n}, 8'h0F);
    check("rst_pending", {7'h0, pending}, 8'h00);
    check("rst_frame_start", {7'h0, frame_start}, 8'h00);
    rst = 1'b0;

    // Scan: the first frame shows the reset word, the next one shows 1234
    do_load(16'h1234, 4'b0000);
    @(negedge clk);
    check("load_pending", {7'h0, pending}, 8'h01);
    expect_digit(0, 8'h3F, "first_frame_d0");
    wait_frame("scan");
    expect_digit(0, 8'h66, "scan_d0");
    expect_digit(1, 8'h4F, "scan_d1");
    expect_digit(2, 8'h5B, "scan_d2");
    expect_digit(3, 8'h06, "scan_d3");

    // Tear-free load in the middle of a frame
    wait_frame("tear_sync");
    wait_digit(2, "tear_d2", ok);
    do_load(16'hABCD, 4'b0000);
    @(negedge clk);
    check("tear_pending", {7'h0, pending}, 8'h01);
    expect_digit(3, 8'h06, "tear_old_d3");
    wait_frame("tear");
    check("tear_pending_clr", {7'h0, pending}, 8'h00);
    expect_digit(0, 8'h5E, "tear_new_d0");

    // A load on the boundary beats the older pending word
    do_load(16'h00F0, 4'b0000);
    hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      if ((m_cnt % FRAME) == FRAME - 1) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    load = 1'b1;
    data = 16'h0005;
    dp   = 4'b0000;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    check("bnd_frame_start", {7'h0, frame_start}, 8'h01);
    check("bnd_pending", {7'h0, pending}, 8'h00);
    expect_digit(0, 8'h6D, "bnd_d0");
    expect_digit(1, 8'h3F, "bnd_d1");

    // Leading-zero blanking
    lzb = 1'b1;
    do_load(16'h0050, 4'b1000);
    wait_frame("lzb");
    expect_digit(0, 8'h3F, "lzb_d0");
    expect_digit(1, 8'h6D, "lzb_d1");
    expect_digit(2, 8'h00, "lzb_d2");
    expect_digit(3, 8'h80, "lzb_d3");
    lzb = 1'b0;
    wait_frame("nolzb");
    expect_digit(2, 8'h3F, "nolzb_d2");
    expect_digit(3, 8'hBF, "nolzb_d3");

    // Reset in the middle of a frame drops a pending word
    wait_frame("rst_sync");
    do_load(16'h7777, 4'b0000);
    wait_digit(2, "rst_d2", ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outbus", outbus, 8'h00);
    check("midrst_digit_n", {4'h0, digit_n}, 8'h0F);
    check("midrst_pending", {7'h0, pending}, 8'h00);
    @(negedge clk);
    check("midrst_guard_outbus", outbus, 8'h00);
    check("midrst_guard_digit_n", {4'h0, digit_n}, 8'h0F);
    @(negedge clk);
    check("midrst_d0_digit_n", {4'h0, digit_n}, 8'h0E);
    check("midrst_d0_outbus", outbus, 8'h3F);

    // Every glyph on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'b0000);
      wait_frame("hex_sync");
      expect_digit(0, {1'b0, seg_lut[v]}, "hex_d0");
    end

    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog in case a task loop never returns
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of sequence, want it before %0t", $time);
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

endmodule
